// File: rtl/dma_request_arbiter.sv
// Four-channel DMA request arbiter with HRQ/HLDA bus-hold sequencing (fixed or rotating priority).
// Latency: request in IDLE -> hrq next cycle; hlda high -> dack/busy next cycle; ending xfer_done -> release next cycle.
// Backpressure: no re-arbitration while granted; new requests wait for a RELEASE/IDLE turnaround.
module dma_request_arbiter #(
    parameter bit DREQ_ACT_LOW  = 1'b0,
    parameter bit DACK_ACT_HIGH = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] dreq,
    input  logic [3:0] sw_req,
    input  logic [3:0] mask,
    input  logic [7:0] mode_xfer,
    input  logic       rot_pri,
    input  logic       ctrl_disable,
    input  logic       hlda,
    input  logic       xfer_done,
    input  logic       tc,
    output logic       hrq,
    output logic [3:0] dack,
    output logic [1:0] chan_active,
    output logic       busy,
    output logic [3:0] sw_req_clr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_DEMAND = 2'b00;
    localparam logic [1:0] MODE_BLOCK  = 2'b10;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] hi;
    logic [1:0] hi_nxt;
    logic [1:0] chan_nxt;
    logic [1:0] winner;
    logic [1:0] base;
    logic [1:0] idx;
    logic [1:0] cur_mode;
    logic [3:0] dreq_act;
    logic [3:0] pend;
    logic [3:0] clr_nxt;
    logic [3:0] dack_oh;
    logic       any_pend;

    assign dreq_act = DREQ_ACT_LOW ? ~dreq : dreq;
    assign pend     = (dreq_act | sw_req) & ~mask;
    assign any_pend = |pend;
    // In fixed mode the search always starts at channel 0.
    assign base     = rot_pri ? hi : 2'd0;
    assign cur_mode = mode_xfer[{chan_active, 1'b0} +: 2];

    // Priority search starting at base with mod-4 wrap; scanning backwards lets the nearest pending channel win.
    always_comb begin
        winner = base;
        idx    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (pend[idx]) begin
                winner = idx;
            end
        end
    end

    // Next-state, grant latch, priority pointer and software-request clear decisions.
    always_comb begin
        state_nxt = state;
        chan_nxt  = chan_active;
        clr_nxt   = 4'b0000;
        hi_nxt    = hi;
        case (state)
            IDLE: begin
                if (any_pend && !ctrl_disable) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (hlda) begin
                    if (any_pend) begin
                        state_nxt = GRANT;
                        chan_nxt  = winner;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end else if (!any_pend) begin
                    state_nxt = RELEASE;
                end
            end
            GRANT: begin
                // Only the end of a transfer cycle can terminate the grant.
                if (xfer_done) begin
                    if (tc) begin
                        clr_nxt   = 4'b0001 << chan_active;
                        state_nxt = RELEASE;
                    end else if (mask[chan_active] || ctrl_disable) begin
                        state_nxt = RELEASE;
                    end else if (cur_mode == MODE_BLOCK) begin
                        state_nxt = GRANT;
                    end else if (cur_mode == MODE_DEMAND && pend[chan_active]) begin
                        state_nxt = GRANT;
                    end else begin
                        state_nxt = RELEASE;
                    end
                    if (state_nxt == RELEASE) begin
                        hi_nxt = chan_active + 2'd1;
                    end
                end
            end
            RELEASE: begin
                // Wait for the CPU to drop hlda before any new request.
                if (!hlda) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!rot_pri) begin
            hi_nxt = 2'd0;
        end
    end

    assign dack_oh = (state_nxt == GRANT) ? (4'b0001 << chan_nxt) : 4'b0000;

    // State register and registered outputs, all derived from the next state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            hrq         <= 1'b0;
            busy        <= 1'b0;
            chan_active <= 2'd0;
            sw_req_clr  <= 4'b0000;
            hi          <= 2'd0;
            dack        <= DACK_ACT_HIGH ? 4'b0000 : 4'b1111;
        end else begin
            state       <= state_nxt;
            hrq         <= (state_nxt == REQ) || (state_nxt == GRANT);
            busy        <= (state_nxt == GRANT);
            chan_active <= chan_nxt;
            sw_req_clr  <= clr_nxt;
            hi          <= hi_nxt;
            dack        <= DACK_ACT_HIGH ? dack_oh : ~dack_oh;
        end
    end

endmodule

// File: tb/tb_dma_request_arbiter.sv
// Testbench for dma_request_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: model advances on each rising edge, outputs compared on the falling edge.
// Backpressure: the bench plays the CPU (hlda) and timing/control (xfer_done/tc) reactively.
module tb_dma_request_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] dreq;
    logic [3:0] sw_req;
    logic [3:0] mask;
    logic [7:0] mode_xfer;
    logic       rot_pri;
    logic       ctrl_disable;
    logic       hlda;
    logic       xfer_done;
    logic       tc;
    logic       hrq;
    logic [3:0] dack;
    logic [1:0] chan_active;
    logic       busy;
    logic [3:0] sw_req_clr;

    int vectors = 0;
    int miscompares = 0;

    dma_request_arbiter dut (
        .CLK(CLK), .RESET(RESET), .dreq(dreq), .sw_req(sw_req), .mask(mask),
        .mode_xfer(mode_xfer), .rot_pri(rot_pri), .ctrl_disable(ctrl_disable),
        .hlda(hlda), .xfer_done(xfer_done), .tc(tc), .hrq(hrq), .dack(dack),
        .chan_active(chan_active), .busy(busy), .sw_req_clr(sw_req_clr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Bus ownership view: holding (hrq up), owning (a channel granted), draining (waiting for hlda low).
    bit         m_valid = 1'b0;
    bit         m_hold, m_own, m_drain;
    int         m_ch, m_hi;
    logic [3:0] m_clr;
    logic [3:0] mp;

    function automatic int pick(input logic [3:0] p, input int start);
        for (int k = 0; k < 4; k++) begin
            if (p[(start + k) % 4]) return (start + k) % 4;
        end
        return start;
    endfunction

    function automatic bit keeps_bus(input logic [1:0] md, input bit still_req);
        return (md == 2'b10) || (md == 2'b00 && still_req);
    endfunction

    // Advance the model on each rising edge from the inputs in effect at that edge.
    always @(posedge CLK) begin
        mp = (dreq | sw_req) & ~mask;
        if (RESET) begin
            m_valid <= 1'b1;
            m_hold  <= 1'b0;
            m_own   <= 1'b0;
            m_drain <= 1'b0;
            m_ch    <= 0;
            m_hi    <= 0;
            m_clr   <= 4'b0000;
        end else begin
            m_clr <= 4'b0000;
            if (m_own) begin
                if (xfer_done && (tc || mask[m_ch] || ctrl_disable ||
                                  !keeps_bus(mode_xfer[m_ch*2 +: 2], mp[m_ch]))) begin
                    m_own   <= 1'b0;
                    m_hold  <= 1'b0;
                    m_drain <= 1'b1;
                    m_hi    <= rot_pri ? (m_ch + 1) % 4 : 0;
                    if (tc) m_clr <= 4'b0001 << m_ch;
                end
            end else if (m_hold) begin
                if (hlda && mp != 4'b0000) begin
                    m_own <= 1'b1;
                    m_ch  <= pick(mp, rot_pri ? m_hi : 0);
                end else if (hlda || mp == 4'b0000) begin
                    m_hold  <= 1'b0;
                    m_drain <= 1'b1;
                end
            end else if (m_drain) begin
                if (!hlda) m_drain <= 1'b0;
            end else if (mp != 4'b0000 && !ctrl_disable) begin
                m_hold <= 1'b1;
            end
            if (!rot_pri) m_hi <= 0;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            check("hrq", {7'd0, hrq}, {7'd0, m_hold});
            check("busy", {7'd0, busy}, {7'd0, m_own});
            check("dack", {4'd0, dack}, m_own ? {4'd0, ~(4'b0001 << m_ch)} : 8'h0F);
            check("sw_req_clr", {4'd0, sw_req_clr}, {4'd0, m_clr});
            if (m_own) check("chan_active", {6'd0, chan_active}, 8'(m_ch));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_hrq();
        int n = 0;
        while (hrq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wait_hrq", {7'd0, hrq}, 8'd1);
    endtask

    task automatic grant();
        wait_hrq();
        hlda = 1'b1;
        tick();
    endtask

    task automatic finish_grant(input logic [3:0] dreq_after);
        xfer_done = 1'b1;
        dreq      = dreq_after;
        tick();
        xfer_done = 1'b0;
        hlda      = 1'b0;
        tick();
    endtask

    initial begin
        RESET = 1'b1; dreq = 4'b0; sw_req = 4'b0; mask = 4'b0; mode_xfer = 8'h55;
        rot_pri = 1'b0; ctrl_disable = 1'b0; hlda = 1'b0; xfer_done = 1'b0; tc = 1'b0;
        tick(); tick();
        check("reset hrq", {7'd0, hrq}, 8'd0);
        check("reset dack", {4'd0, dack}, 8'h0F);
        check("reset busy", {7'd0, busy}, 8'd0);
        check("reset chan", {6'd0, chan_active}, 8'd0);
        check("reset clr", {4'd0, sw_req_clr}, 8'd0);
        RESET = 1'b0;

        // Fixed priority: ch1 beats ch3, then ch3 served after the turnaround.
        dreq = 4'b1010;
        tick();
        check("fix hrq", {7'd0, hrq}, 8'd1);
        tick(); tick();
        hlda = 1'b1;
        tick();
        check("fix dack1", {4'd0, dack}, 8'h0D);
        check("fix chan1", {6'd0, chan_active}, 8'd1);
        xfer_done = 1'b1; dreq = 4'b1000;
        tick();
        xfer_done = 1'b0;
        check("fix release hrq", {7'd0, hrq}, 8'd0);
        check("fix release dack", {4'd0, dack}, 8'h0F);
        hlda = 1'b0;
        tick();
        grant();
        check("fix dack3", {4'd0, dack}, 8'h07);
        check("fix chan3", {6'd0, chan_active}, 8'd3);
        finish_grant(4'b0000);
        tick();

        // Block mode on ch2: held through three transfers, terminal count ends it.
        mode_xfer = 8'b0010_0000; dreq = 4'b0100;
        grant();
        check("blk dack", {4'd0, dack}, 8'h0B);
        for (int i = 0; i < 3; i++) begin
            xfer_done = 1'b1;
            tick();
            xfer_done = 1'b0;
            check("blk hold", {4'd0, dack}, 8'h0B);
        end
        xfer_done = 1'b1; tc = 1'b1;
        tick();
        xfer_done = 1'b0; tc = 1'b0;
        check("blk clr", {4'd0, sw_req_clr}, 8'h04);
        check("blk hrq", {7'd0, hrq}, 8'd0);
        check("blk dack off", {4'd0, dack}, 8'h0F);
        tick();
        check("blk clr pulse", {4'd0, sw_req_clr}, 8'h00);
        dreq = 4'b0000; hlda = 1'b0;
        tick(); tick();

        // Demand mode on ch0.
        mode_xfer = 8'h00; dreq = 4'b0001;
        grant();
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        check("dem stay", {7'd0, busy}, 8'd1);
        dreq = 4'b0000;
        tick();
        check("dem mid-cycle", {7'd0, busy}, 8'd1);
        finish_grant(4'b0000);
        check("dem end", {7'd0, busy}, 8'd0);
        tick();

        // Request masked while waiting for hlda.
        mode_xfer = 8'h55; dreq = 4'b0001;
        wait_hrq();
        mask = 4'b0001;
        tick();
        check("mask hrq", {7'd0, hrq}, 8'd0);
        check("mask dack", {4'd0, dack}, 8'h0F);
        mask = 4'b0000; dreq = 4'b0000;
        tick(); tick();

        // Disabled controller never requests the bus.
        ctrl_disable = 1'b1; dreq = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("disable hrq", {7'd0, hrq}, 8'd0);
        end
        ctrl_disable = 1'b0; dreq = 4'b0000;
        tick();

        // Rotating priority, all requesting: 0,1,2,3,0.
        rot_pri = 1'b1; dreq = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            grant();
            check("rot order", {6'd0, chan_active}, 8'(i % 4));
            finish_grant(4'b1111);
        end

        // Reset during a grant of ch1; pointer returns to 0.
        grant();
        check("rst pre chan", {6'd0, chan_active}, 8'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0; hlda = 1'b0;
        check("rst hrq", {7'd0, hrq}, 8'd0);
        check("rst dack", {4'd0, dack}, 8'h0F);
        check("rst busy", {7'd0, busy}, 8'd0);
        grant();
        check("rst hi", {6'd0, chan_active}, 8'd0);
        finish_grant(4'b0000);
        rot_pri = 1'b0;
        tick();

        // Randomized traffic; the bench behaves as CPU and timing/control.
        for (int n = 0; n < 4000; n++) begin
            tick();
            RESET = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 7) == 0) dreq = 4'($urandom);
            sw_req = sw_req & ~sw_req_clr;
            if ($urandom_range(0, 15) == 0) sw_req = sw_req | 4'($urandom);
            if ($urandom_range(0, 19) == 0) mask = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 49) == 0) mode_xfer = 8'($urandom);
            if ($urandom_range(0, 99) == 0) rot_pri = ~rot_pri;
            ctrl_disable = ($urandom_range(0, 30) == 0);
            if (hrq && !hlda && $urandom_range(0, 2) == 0) hlda = 1'b1;
            else if (!hrq && hlda && $urandom_range(0, 1) == 0) hlda = 1'b0;
            xfer_done = busy && ($urandom_range(0, 2) == 0);
            tc = xfer_done && ($urandom_range(0, 4) == 0);
        end
        RESET = 1'b0; xfer_done = 1'b0; tc = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
